psum_writeback_ctrl: RTL and testbench
======================================

Name: psum_writeback_ctrl

Overview:
- Write-side partner of the processing element's partial-sum read path.
- Issues partial-sum BRAM read addresses in lockstep with PE launches.
- Accepts the PE's fp16 result pixels and writes them back to the partial-sum BRAM at the matching address.
- Sequences input-channel passes over one output feature map: forces a zero partial sum on pass 0, applies optional ReLU on the final pass, and signals completion.

Parameters:
- ADDR_W, 10, partial-sum BRAM address width
- MAP_W, 26, output map width in pixels
- MAP_H, 26, output map height in pixels
- PE_LAT, 2, cycles from issue_valid to the matching pix_valid (informational; the block tracks order, not timing)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begins a map computation
- num_passes  in  8  input-channel passes; sampled on start; 0 is treated as 1
- relu_en  in  1  sampled on start; clamp negatives on the final pass
- issue_valid  in  1  feeder launched one PE operation this cycle
- pix_valid  in  1  PE result valid this cycle
- pixel  in  16  fp16 PE result
- rd_en  out  1  partial-sum BRAM read enable
- rd_addr  out  ADDR_W  partial-sum BRAM read address
- psum_zero  out  1  aligned with BRAM read data (1 cycle after rd_en); forces the partial-sum operand to 0
- wr_en  out  1  partial-sum BRAM write enable
- wr_addr  out  ADDR_W  write address
- wr_data  out  16  write data
- busy  out  1  high from the cycle after an accepted start until done
- pass_done  out  1  one-cycle pulse when a pass's last write occurs
- done  out  1  one-cycle pulse when the final pass's last write occurs
- err  out  1  sticky protocol-error flag; cleared only by rst or an accepted start

Behaviour:
- N = MAP_W*MAP_H. Elaboration fails if N > 2^ADDR_W or N < PE_LAT+2; the lower bound guarantees there is no read-after-write hazard across passes.
- Reset values:
  - All outputs 0.
  - Counters 0.
  - FSM in IDLE.
  - Reset mid-operation aborts with no further writes.
- FSM states: IDLE, RUN, FINISH.
  - IDLE: on start, latch num_passes (0 becomes 1) and relu_en; clear counters and err; go to RUN; busy=1 next cycle.
  - RUN: handles issue and write traffic (see below). On the final write of the final pass, go to FINISH.
  - FINISH: done=1 for one cycle, busy=0, return to IDLE.
- start while busy is ignored; err is unchanged.
- Issue side (RUN only):
  - issue_valid produces registered rd_en=1 and rd_addr=issue_cnt on the next cycle.
  - issue_cnt counts 0..N-1 and wraps; issue_pass increments on wrap.
  - psum_zero=1 one cycle after rd_en when that read belongs to pass 0.
  - issue_valid after all num_passes*N issues, or while IDLE: ignored, err=1.
- Write side (RUN only):
  - pix_valid produces registered wr_en=1, wr_addr=wr_cnt and wr_data next cycle. Write latency is 1 cycle.
  - wr_cnt wraps at N-1; wr_pass increments on wrap.
  - pass_done pulses with the write of address N-1.
  - On the final pass, if relu_en=1 and pixel[15]=1, wr_data=16'h0000; otherwise wr_data=pixel. -0 (16'h8000) also clamps to 0.
  - pix_valid while IDLE or FINISH: ignored, no write, err=1.
  - pix_valid when writes are not behind issues (wr total == issue total): err=1, write still performed.
- issue_valid and pix_valid in the same cycle are both serviced independently.
- done and pass_done are asserted together on the last write. done rises the cycle after that write's wr_en.

Test Plan:
- Setup for all scenarios: MAP_W=2, MAP_H=2 (N=4).
- Single pass:
  - Stimulus: start with num_passes=1, relu_en=0; 4 issues; 4 pixels 16'h3C00, 16'h4000, 16'hBC00, 16'h4200, each PE_LAT after its issue.
  - Required: rd_addr 0..3 with psum_zero=1 each; wr_addr 0..3 with matching data; pass_done and done pulses; busy falls.
- Three passes:
  - Stimulus: num_passes=3, 12 back-to-back issues.
  - Required: rd_addr sequence 0,1,2,3 repeated 3 times; psum_zero only on the first 4; pass_done pulses 3 times; done once, at the 12th write.
- ReLU:
  - Stimulus: num_passes=2, relu_en=1; last-pass pixels 16'hBC00, 16'h8000, 16'h3C00, 16'hC400.
  - Required: final writes 0000, 0000, 3C00, 0000. Pass-0 negatives are written unclamped.
- Protocol errors:
  - Stimulus: pix_valid in IDLE.
  - Required: no wr_en, err=1. A later start clears err.
  - Stimulus: 5th issue in a 1-pass job.
  - Required: no rd_en, err=1.
- Reset and start-while-busy:
  - Stimulus: rst asserted after 2 writes.
  - Required: outputs 0 immediately; no writes after reset.
  - Stimulus: a fresh start, followed by start while busy.
  - Required: the second start is ignored and the counters are unchanged.
- Simultaneous events and num_passes=0:
  - Stimulus: issue_valid and pix_valid in the same cycle.
  - Required: rd_en and wr_en assert in the same next cycle.
  - Stimulus: num_passes=0.
  - Required: behaves as 1 pass, with done after 4 writes.

Source files
------------

// File: rtl/psum_writeback_ctrl.sv
// Partial-sum writeback controller: issues psum BRAM reads in step with PE launches,
// writes PE results back in order, and sequences input-channel passes over one output map.
// Latency: rd_en/wr_en one cycle after issue_valid/pix_valid; psum_zero one cycle after rd_en.
// Backpressure: none. Every accepted event is serviced at once; out-of-protocol events set err.
module psum_writeback_ctrl #(
    parameter int ADDR_W = 10,
    parameter int MAP_W  = 26,
    parameter int MAP_H  = 26,
    parameter int PE_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        num_passes,
    input  logic              relu_en,
    input  logic              issue_valid,
    input  logic              pix_valid,
    input  logic [15:0]       pixel,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              psum_zero,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              busy,
    output logic              pass_done,
    output logic              done,
    output logic              err
);

    // Pixels per output map; one BRAM word per pixel.
    localparam int N = MAP_W * MAP_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

    // The map must fit the BRAM, and must be long enough that a read of pass p+1
    // can never overtake the write of the same address from pass p.
    generate
        if ((N > (1 << ADDR_W)) || (N < PE_LAT + 2)) begin : g_bad_cfg
            $error("psum_writeback_ctrl: map size out of range for ADDR_W / PE_LAT");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t              state_q, state_d;

    // Job configuration captured on start.
    logic [7:0]          passes_q, passes_d;
    logic                relu_q, relu_d;

    // Issue-side position: address within the map and pass index.
    logic [ADDR_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [7:0]          issue_pass_q, issue_pass_d;

    // Write-side position.
    logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [7:0]          wr_pass_q, wr_pass_d;

    // Registered outputs.
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                rd_pass0_q, rd_pass0_d;
    logic                psum_zero_q, psum_zero_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [15:0]         wr_data_q, wr_data_d;
    logic                busy_q, busy_d;
    logic                pass_done_q, pass_done_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    // Decoded conditions on the current position.
    logic                issue_exhausted;
    logic                writes_caught_up;
    logic                wr_final_pass;
    logic                wr_last_addr;

    assign issue_exhausted  = (issue_pass_q == passes_q);
    assign writes_caught_up = (wr_pass_q == issue_pass_q) && (wr_cnt_q == issue_cnt_q);
    assign wr_final_pass    = (wr_pass_q == (passes_q - 8'd1));
    assign wr_last_addr     = (wr_cnt_q == LAST_ADDR);

    // Next-state and next-output decode for the whole controller.
    always_comb begin
        state_d      = state_q;
        passes_d     = passes_q;
        relu_d       = relu_q;
        issue_cnt_d  = issue_cnt_q;
        issue_pass_d = issue_pass_q;
        wr_cnt_d     = wr_cnt_q;
        wr_pass_d    = wr_pass_q;
        rd_en_d      = 1'b0;
        rd_addr_d    = rd_addr_q;
        rd_pass0_d   = rd_pass0_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        busy_d       = busy_q;
        pass_done_d  = 1'b0;
        done_d       = 1'b0;
        err_d        = err_q;

        // The BRAM returns data one cycle after rd_en; flag it as a zero operand
        // when that read belongs to the first pass.
        psum_zero_d  = rd_en_q & rd_pass0_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    passes_d     = (num_passes == 8'd0) ? 8'd1 : num_passes;
                    relu_d       = relu_en;
                    issue_cnt_d  = '0;
                    issue_pass_d = 8'd0;
                    wr_cnt_d     = '0;
                    wr_pass_d    = 8'd0;
                    err_d        = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = S_RUN;
                end
                // No job running: any traffic is a protocol violation.
                if (issue_valid || pix_valid) begin
                    err_d = 1'b1;
                end
            end

            S_RUN: begin
                // Issue side: one read per PE launch, in map order, pass after pass.
                if (issue_valid) begin
                    if (issue_exhausted) begin
                        err_d = 1'b1;
                    end else begin
                        rd_en_d    = 1'b1;
                        rd_addr_d  = issue_cnt_q;
                        rd_pass0_d = (issue_pass_q == 8'd0);
                        if (issue_cnt_q == LAST_ADDR) begin
                            issue_cnt_d  = '0;
                            issue_pass_d = issue_pass_q + 8'd1;
                        end else begin
                            issue_cnt_d  = issue_cnt_q + ADDR_W'(1);
                        end
                    end
                end

                // Write side: results come back in issue order, so the write
                // address is simply the running write position.
                if (pix_valid) begin
                    // A result with no outstanding launch is flagged but still written.
                    if (writes_caught_up) begin
                        err_d = 1'b1;
                    end
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_cnt_q;
                    // Sign bit set means negative (including -0); clamp on the last pass.
                    if (wr_final_pass && relu_q && pixel[15]) begin
                        wr_data_d = 16'h0000;
                    end else begin
                        wr_data_d = pixel;
                    end

                    if (wr_last_addr) begin
                        wr_cnt_d  = '0;
                        wr_pass_d = wr_pass_q + 8'd1;
                        if (wr_final_pass) begin
                            // Final pass_done is held back to coincide with done.
                            state_d = S_FINISH;
                        end else begin
                            pass_done_d = 1'b1;
                        end
                    end else begin
                        wr_cnt_d = wr_cnt_q + ADDR_W'(1);
                    end
                end
            end

            S_FINISH: begin
                done_d      = 1'b1;
                pass_done_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
                if (issue_valid || pix_valid) begin
                    err_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs; reset aborts any job in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            passes_q     <= 8'd0;
            relu_q       <= 1'b0;
            issue_cnt_q  <= '0;
            issue_pass_q <= 8'd0;
            wr_cnt_q     <= '0;
            wr_pass_q    <= 8'd0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            rd_pass0_q   <= 1'b0;
            psum_zero_q  <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 16'h0000;
            busy_q       <= 1'b0;
            pass_done_q  <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            passes_q     <= passes_d;
            relu_q       <= relu_d;
            issue_cnt_q  <= issue_cnt_d;
            issue_pass_q <= issue_pass_d;
            wr_cnt_q     <= wr_cnt_d;
            wr_pass_q    <= wr_pass_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            rd_pass0_q   <= rd_pass0_d;
            psum_zero_q  <= psum_zero_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            pass_done_q  <= pass_done_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign psum_zero = psum_zero_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign pass_done = pass_done_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_psum_writeback_ctrl.sv
// Bench for psum_writeback_ctrl on a 2x2 map: a transaction-level model (running
// issue/write totals) is compared with the DUT on every falling edge, and
// per-scenario logs are checked against hand-computed literal values.
module tb_psum_writeback_ctrl;

    localparam int AW = 10;
    localparam int N  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    num_passes = 8'd0;
    logic          relu_en = 1'b0;
    logic          issue_valid = 1'b0;
    logic          pix_valid = 1'b0;
    logic [15:0]   pixel = 16'h0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          psum_zero;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          busy;
    logic          pass_done;
    logic          done;
    logic          err;

    psum_writeback_ctrl #(.ADDR_W(AW), .MAP_W(2), .MAP_H(2), .PE_LAT(2)) dut (
        .clk(clk), .rst(rst), .start(start), .num_passes(num_passes), .relu_en(relu_en),
        .issue_valid(issue_valid), .pix_valid(pix_valid), .pixel(pixel),
        .rd_en(rd_en), .rd_addr(rd_addr), .psum_zero(psum_zero),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .pass_done(pass_done), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Job described by totals: reads issued so far, writes done so far, total = passes*N.
    logic          e_rd_en, e_psum_zero, e_wr_en, e_busy, e_pass_done, e_done, e_err;
    logic [AW-1:0] e_rd_addr, e_wr_addr;
    logic [15:0]   e_wr_data;
    int            m_mode;      // 0 no job, 1 job active, 2 last write just made
    int            m_passes, m_issues, m_writes, m_total, m_iss_before;
    bit            m_relu, m_prev_rd_p0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e_rd_en = 0; e_rd_addr = '0; e_psum_zero = 0; e_wr_en = 0; e_wr_addr = '0;
            e_wr_data = 16'h0; e_busy = 0; e_pass_done = 0; e_done = 0; e_err = 0;
            m_mode = 0; m_issues = 0; m_writes = 0; m_prev_rd_p0 = 0; m_passes = 1; m_relu = 0;
        end else begin
            e_psum_zero  = e_rd_en && m_prev_rd_p0;
            e_rd_en = 0; e_wr_en = 0; e_pass_done = 0; e_done = 0;
            m_total      = m_passes * N;
            m_iss_before = m_issues;
            case (m_mode)
                0: begin
                    if (start) begin
                        m_passes = (num_passes == 0) ? 1 : int'(num_passes);
                        m_relu = relu_en; m_issues = 0; m_writes = 0;
                        e_err = 0; e_busy = 1; m_mode = 1;
                    end
                    if (issue_valid || pix_valid) e_err = 1;
                end
                1: begin
                    if (issue_valid) begin
                        if (m_issues >= m_total) e_err = 1;
                        else begin
                            e_rd_en = 1; e_rd_addr = AW'(m_issues % N);
                            m_prev_rd_p0 = (m_issues < N); m_issues++;
                        end
                    end
                    if (pix_valid) begin
                        if (m_writes >= m_iss_before) e_err = 1;
                        e_wr_en = 1; e_wr_addr = AW'(m_writes % N);
                        e_wr_data = (m_relu && (m_writes / N == m_passes - 1) && pixel[15]) ? 16'h0 : pixel;
                        m_writes++;
                        if (m_writes == m_total) m_mode = 2;
                        else if (m_writes % N == 0) e_pass_done = 1;
                    end
                end
                default: begin
                    e_done = 1; e_pass_done = 1; e_busy = 0; m_mode = 0;
                    if (issue_valid || pix_valid) e_err = 1;
                end
            endcase
        end
    end

    // ---------------- compare + logging ----------------
    logic [AW-1:0] rd_log[$];
    logic [AW-1:0] wa_log[$];
    logic [15:0]   wd_log[$];
    int n_pz, n_pd, n_done, n_both;

    always @(negedge clk) begin
        check("rd_en", 32'(rd_en), 32'(e_rd_en));
        if (e_rd_en || rst) check("rd_addr", 32'(rd_addr), 32'(e_rd_addr));
        check("psum_zero", 32'(psum_zero), 32'(e_psum_zero));
        check("wr_en", 32'(wr_en), 32'(e_wr_en));
        if (e_wr_en || rst) begin
            check("wr_addr", 32'(wr_addr), 32'(e_wr_addr));
            check("wr_data", 32'(wr_data), 32'(e_wr_data));
        end
        check("busy", 32'(busy), 32'(e_busy));
        check("pass_done", 32'(pass_done), 32'(e_pass_done));
        check("done", 32'(done), 32'(e_done));
        check("err", 32'(err), 32'(e_err));
        if (rd_en) rd_log.push_back(rd_addr);
        if (wr_en) begin wa_log.push_back(wr_addr); wd_log.push_back(wr_data); end
        if (psum_zero) n_pz++;
        if (pass_done) n_pd++;
        if (done) n_done++;
        if (rd_en && wr_en) n_both++;
    end

    // ---------------- stimulus ----------------
    logic [15:0] pix_tab [12];
    logic        err_after_start;

    task automatic step(input bit st, input bit iv, input bit pv, input logic [15:0] px);
        start = st; issue_valid = iv; pix_valid = pv; pixel = px;
        @(posedge clk); #1;
        start = 0; issue_valid = 0; pix_valid = 0;
    endtask

    task automatic clear_logs();
        rd_log.delete(); wa_log.delete(); wd_log.delete();
        n_pz = 0; n_pd = 0; n_done = 0; n_both = 0;
    endtask

    // Start a job, issue back-to-back, return each pixel PE_LAT=2 cycles after its issue.
    task automatic run_job(input int np, input bit re, input int n_iss, input int n_pix, input int restart_at);
        clear_logs();
        num_passes = 8'(np); relu_en = re;
        step(1, 0, 0, 16'h0);
        err_after_start = err;
        for (int k = 0; k < n_pix + 8; k++) begin
            bit pv;
            pv = (k >= 2) && (k - 2 < n_pix);
            if (k == restart_at) num_passes = 8'd1;
            step(k == restart_at, k < n_iss, pv, pv ? pix_tab[k - 2] : 16'h0);
        end
    endtask

    initial begin
        logic [15:0] s1 [4];
        logic [15:0] relu_exp [4];
        s1 = '{16'h3C00, 16'h4000, 16'hBC00, 16'h4200};
        relu_exp = '{16'h0000, 16'h0000, 16'h3C00, 16'h0000};
        clear_logs();
        #2 rst = 1;
        @(posedge clk); #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_wr_en", 32'(wr_en), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;

        // Single pass.
        for (int i = 0; i < 12; i++) pix_tab[i] = (i < 4) ? s1[i] : 16'h0;
        run_job(1, 0, 4, 4, -1);
        check("s1_wr_count", wd_log.size(), 4);
        for (int i = 0; i < wd_log.size() && i < 4; i++) begin
            check("s1_wr_data", 32'(wd_log[i]), 32'(s1[i]));
            check("s1_wr_addr", 32'(wa_log[i]), i);
        end
        check("s1_rd_count", rd_log.size(), 4);
        for (int i = 0; i < rd_log.size() && i < 4; i++) check("s1_rd_addr", 32'(rd_log[i]), i);
        check("s1_psum_zero", n_pz, 4);
        check("s1_pass_done", n_pd, 1);
        check("s1_done", n_done, 1);
        check("s1_simul_rd_wr", n_both, 2);
        check("s1_busy_end", 32'(busy), 32'd0);

        // Three passes.
        for (int i = 0; i < 12; i++) pix_tab[i] = 16'h3C00 + 16'(i);
        run_job(3, 0, 12, 12, -1);
        check("s2_rd_count", rd_log.size(), 12);
        for (int i = 0; i < rd_log.size() && i < 12; i++) check("s2_rd_addr", 32'(rd_log[i]), i % 4);
        check("s2_psum_zero", n_pz, 4);
        check("s2_pass_done", n_pd, 3);
        check("s2_done", n_done, 1);
        check("s2_wr_count", wd_log.size(), 12);

        // ReLU on the final of two passes.
        pix_tab = '{16'hBC00, 16'h3C00, 16'hC000, 16'h4000,
                    16'hBC00, 16'h8000, 16'h3C00, 16'hC400, 16'h0, 16'h0, 16'h0, 16'h0};
        run_job(2, 1, 8, 8, -1);
        check("s3_wr_count", wd_log.size(), 8);
        if (wd_log.size() == 8) begin
            check("s3_pass0_neg_a", 32'(wd_log[0]), 32'h0000BC00);
            check("s3_pass0_neg_b", 32'(wd_log[2]), 32'h0000C000);
            for (int i = 0; i < 4; i++) check("s3_relu_data", 32'(wd_log[4 + i]), 32'(relu_exp[i]));
        end

        // Protocol errors: pixel while idle, then a 5th issue in a 1-pass job.
        clear_logs();
        step(0, 0, 1, 16'h1234);
        check("s4_idle_pix_wr_en", 32'(wr_en), 32'd0);
        check("s4_idle_pix_err", 32'(err), 32'd1);
        for (int i = 0; i < 12; i++) pix_tab[i] = (i < 4) ? s1[i] : 16'h0;
        run_job(1, 0, 5, 4, -1);
        check("s4_start_clears_err", 32'(err_after_start), 32'd0);
        check("s4_rd_count", rd_log.size(), 4);
        check("s4_err_sticky", 32'(err), 32'd1);
        check("s4_wr_count", wd_log.size(), 4);

        // Reset after two writes of a 3-pass job.
        clear_logs();
        num_passes = 8'd3; relu_en = 0;
        step(1, 0, 0, 16'h0);
        step(0, 1, 0, 16'h0);
        step(0, 1, 0, 16'h0);
        step(0, 1, 1, 16'h1111);
        step(0, 1, 1, 16'h2222);
        step(0, 0, 0, 16'h0);
        check("s5_writes_before_rst", wd_log.size(), 2);
        rst = 1; #1;
        check("s5_rst_wr_en", 32'(wr_en), 32'd0);
        check("s5_rst_rd_en", 32'(rd_en), 32'd0);
        check("s5_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 0;
        step(0, 0, 1, 16'h3333);
        step(0, 0, 1, 16'h4444);
        check("s5_no_writes_after_rst", wd_log.size(), 2);

        // Start while busy is ignored; the 3-pass job completes unchanged.
        for (int i = 0; i < 12; i++) pix_tab[i] = 16'h4000 + 16'(i);
        run_job(3, 0, 12, 12, 5);
        check("s6_rd_count", rd_log.size(), 12);
        for (int i = 0; i < rd_log.size() && i < 12; i++) check("s6_rd_addr", 32'(rd_log[i]), i % 4);
        check("s6_pass_done", n_pd, 3);
        check("s6_done", n_done, 1);
        check("s6_err", 32'(err), 32'd0);

        // num_passes = 0 behaves as one pass.
        for (int i = 0; i < 12; i++) pix_tab[i] = (i < 4) ? s1[i] : 16'h0;
        run_job(0, 0, 4, 4, -1);
        check("s7_wr_count", wd_log.size(), 4);
        check("s7_pass_done", n_pd, 1);
        check("s7_done", n_done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
